// File: rtl/addition_stage4_normalizer.sv
// Final normalization stage of a floating-point adder: takes the raw mantissa sum and the
// common exponent, renormalizes by one right shift or iterative left shifts, and flags results.
module addition_stage4_normalizer #(
    parameter int unsigned MENT_WIDTH = 23,
    parameter int unsigned EXP_WIDTH  = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic [MENT_WIDTH+1:0] sum_in,
    input  logic [EXP_WIDTH-1:0]  exponent_in,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic [MENT_WIDTH-1:0] mentissa_out,
    output logic [EXP_WIDTH-1:0]  exponent_out,
    output logic                  zero_out,
    output logic                  overflow_out,
    output logic                  underflow_out
);

    localparam int unsigned SumWidth = MENT_WIDTH + 2;
    localparam logic [EXP_WIDTH-1:0] ExpMax = {EXP_WIDTH{1'b1}};
    localparam logic [EXP_WIDTH-1:0] ExpOvf = {{(EXP_WIDTH-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StShift,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [SumWidth-1:0]   sum_q, sum_d;
    logic [EXP_WIDTH-1:0]  exp_q, exp_d;
    logic                  flag_zero_q, flag_zero_d;
    logic                  flag_ovf_q, flag_ovf_d;
    logic                  flag_unf_q, flag_unf_d;

    logic                  valid_q, valid_d;
    logic [MENT_WIDTH-1:0] mant_out_q, mant_out_d;
    logic [EXP_WIDTH-1:0]  exp_out_q, exp_out_d;
    logic                  zero_out_q, zero_out_d;
    logic                  ovf_out_q, ovf_out_d;
    logic                  unf_out_q, unf_out_d;

    assign ready_out     = (state_q == StIdle);
    assign valid_out     = valid_q;
    assign mentissa_out  = mant_out_q;
    assign exponent_out  = exp_out_q;
    assign zero_out      = zero_out_q;
    assign overflow_out  = ovf_out_q;
    assign underflow_out = unf_out_q;

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        exp_d       = exp_q;
        flag_zero_d = flag_zero_q;
        flag_ovf_d  = flag_ovf_q;
        flag_unf_d  = flag_unf_q;
        valid_d     = valid_q;
        mant_out_d  = mant_out_q;
        exp_out_d   = exp_out_q;
        zero_out_d  = zero_out_q;
        ovf_out_d   = ovf_out_q;
        unf_out_d   = unf_out_q;

        unique case (state_q)
            StIdle: begin
                if (valid_in) begin
                    sum_d       = sum_in;
                    exp_d       = exponent_in;
                    flag_zero_d = 1'b0;
                    flag_ovf_d  = 1'b0;
                    flag_unf_d  = 1'b0;
                    state_d     = StCheck;
                end
            end
            StCheck: begin
                if (sum_q == '0) begin
                    exp_d       = '0;
                    flag_zero_d = 1'b1;
                    state_d     = StDone;
                end else if (sum_q[SumWidth-1]) begin
                    // Carry out: one right shift; saturate to infinity near the top exponent.
                    if (exp_q >= ExpOvf) begin
                        sum_d      = '0;
                        exp_d      = ExpMax;
                        flag_ovf_d = 1'b1;
                    end else begin
                        sum_d = sum_q >> 1;
                        exp_d = exp_q + 1'b1;
                    end
                    state_d = StDone;
                end else if (sum_q[MENT_WIDTH]) begin
                    state_d = StDone;
                end else begin
                    state_d = StShift;
                end
            end
            StShift: begin
                if (exp_q == '0) begin
                    sum_d      = '0;
                    flag_unf_d = 1'b1;
                    state_d    = StDone;
                end else begin
                    sum_d = sum_q << 1;
                    exp_d = exp_q - 1'b1;
                    if (sum_q[MENT_WIDTH-1]) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                // First DONE cycle publishes the result; it then holds until taken.
                if (!valid_q) begin
                    valid_d    = 1'b1;
                    mant_out_d = sum_q[MENT_WIDTH-1:0];
                    exp_out_d  = exp_q;
                    zero_out_d = flag_zero_q;
                    ovf_out_d  = flag_ovf_q;
                    unf_out_d  = flag_unf_q;
                end else if (ready_in) begin
                    valid_d    = 1'b0;
                    mant_out_d = '0;
                    exp_out_d  = '0;
                    zero_out_d = 1'b0;
                    ovf_out_d  = 1'b0;
                    unf_out_d  = 1'b0;
                    state_d    = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= StIdle;
            sum_q       <= '0;
            exp_q       <= '0;
            flag_zero_q <= 1'b0;
            flag_ovf_q  <= 1'b0;
            flag_unf_q  <= 1'b0;
            valid_q     <= 1'b0;
            mant_out_q  <= '0;
            exp_out_q   <= '0;
            zero_out_q  <= 1'b0;
            ovf_out_q   <= 1'b0;
            unf_out_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            exp_q       <= exp_d;
            flag_zero_q <= flag_zero_d;
            flag_ovf_q  <= flag_ovf_d;
            flag_unf_q  <= flag_unf_d;
            valid_q     <= valid_d;
            mant_out_q  <= mant_out_d;
            exp_out_q   <= exp_out_d;
            zero_out_q  <= zero_out_d;
            ovf_out_q   <= ovf_out_d;
            unf_out_q   <= unf_out_d;
        end
    end

endmodule

// File: tb/tb_addition_stage4_normalizer.sv
// Directed bench for addition_stage4_normalizer: vector table plus stall and reset sequences.
module tb_addition_stage4_normalizer;

    logic        clk_in;
    logic        rst_n_in;
    logic        valid_in;
    logic        ready_out;
    logic [24:0] sum_in;
    logic [7:0]  exponent_in;
    logic        valid_out;
    logic        ready_in;
    logic [22:0] mentissa_out;
    logic [7:0]  exponent_out;
    logic        zero_out;
    logic        overflow_out;
    logic        underflow_out;

    int n_cmp = 0;
    int n_err = 0;

    addition_stage4_normalizer #(
        .MENT_WIDTH(23),
        .EXP_WIDTH (8)
    ) dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .sum_in       (sum_in),
        .exponent_in  (exponent_in),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .mentissa_out (mentissa_out),
        .exponent_out (exponent_out),
        .zero_out     (zero_out),
        .overflow_out (overflow_out),
        .underflow_out(underflow_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [24:0] sum;
        logic [7:0]  exp;
        int          lat;
        logic [22:0] mant;
        logic [7:0]  expo;
        logic [2:0]  flags; // {zero, overflow, underflow}
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string tag, input string what, input logic [31:0] act,
                         input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s.%s: got %0h required %0h", tag, what, act, req);
        end
    endtask

    function automatic logic [2:0] flags_now();
        return {zero_out, overflow_out, underflow_out};
    endfunction

    // Called at posedge+1 with the DUT idle and ready_in high.
    task automatic run_op(input vec_t v, input string tag);
        int n;
        bit seen;
        check(tag, "ready_before", {31'b0, ready_out}, 32'd1);
        valid_in    = 1'b1;
        sum_in      = v.sum;
        exponent_in = v.exp;
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(posedge clk_in);
            #1;
            n++;
            if (valid_out) seen = 1'b1;
        end
        check(tag, "latency", n, v.lat);
        check(tag, "mant", {9'b0, mentissa_out}, {9'b0, v.mant});
        check(tag, "exp", {24'b0, exponent_out}, {24'b0, v.expo});
        check(tag, "flags", {29'b0, flags_now()}, {29'b0, v.flags});
        check(tag, "ready_in_done", {31'b0, ready_out}, 32'd0);
        @(posedge clk_in);
        #1;
        check(tag, "valid_after_take", {31'b0, valid_out}, 32'd0);
        check(tag, "flags_after_take", {29'b0, flags_now()}, 32'd0);
        check(tag, "ready_after_take", {31'b0, ready_out}, 32'd1);
    endtask

    initial begin
        int n;
        bit bad;

        vecs[0]  = '{25'h0C00000, 8'h7F, 2,  23'h400000, 8'h7F, 3'b000};
        vecs[1]  = '{25'h1800000, 8'h80, 2,  23'h400000, 8'h81, 3'b000};
        vecs[2]  = '{25'h1800000, 8'hFE, 2,  23'h000000, 8'hFF, 3'b010};
        vecs[3]  = '{25'h0000001, 8'h80, 25, 23'h000000, 8'h69, 3'b000};
        vecs[4]  = '{25'h0000000, 8'h55, 2,  23'h000000, 8'h00, 3'b100};
        vecs[5]  = '{25'h0000100, 8'h05, 8,  23'h000000, 8'h00, 3'b001};
        vecs[6]  = '{25'h1FFFFFF, 8'hFD, 2,  23'h7FFFFF, 8'hFE, 3'b000};
        vecs[7]  = '{25'h0400000, 8'h10, 3,  23'h000000, 8'h0F, 3'b000};
        vecs[8]  = '{25'h0000100, 8'h0F, 17, 23'h000000, 8'h00, 3'b000};
        vecs[9]  = '{25'h0000100, 8'h0E, 17, 23'h000000, 8'h00, 3'b001};
        vecs[10] = '{25'h0A5A5A5, 8'h01, 2,  23'h25A5A5, 8'h01, 3'b000};
        vecs[11] = '{25'h1000001, 8'h00, 2,  23'h000000, 8'h01, 3'b000};

        rst_n_in    = 1'b0;
        valid_in    = 1'b0;
        ready_in    = 1'b1;
        sum_in      = '0;
        exponent_in = '0;
        #3;
        check("reset", "valid", {31'b0, valid_out}, 32'd0);
        check("reset", "ready", {31'b0, ready_out}, 32'd1);
        check("reset", "mant", {9'b0, mentissa_out}, 32'd0);
        check("reset", "exp", {24'b0, exponent_out}, 32'd0);
        check("reset", "flags", {29'b0, flags_now()}, 32'd0);
        repeat (2) @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Stall in DONE for 10 cycles while offering a different operand.
        ready_in    = 1'b0;
        valid_in    = 1'b1;
        sum_in      = 25'h0C00000;
        exponent_in = 8'h7F;
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
        n = 0;
        while (!valid_out && n < 20) begin
            @(posedge clk_in);
            #1;
            n++;
        end
        check("stall", "latency", n, 32'd2);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            valid_in    = 1'b1;
            sum_in      = 25'h1800000;
            exponent_in = 8'hFE;
            @(posedge clk_in);
            #1;
            if (!valid_out || ready_out || mentissa_out !== 23'h400000 || exponent_out !== 8'h7F
                || flags_now() !== 3'b000) begin
                bad = 1'b1;
            end
        end
        check("stall", "held_outputs", {31'b0, bad}, 32'd0);
        valid_in = 1'b0;
        ready_in = 1'b1;
        @(posedge clk_in);
        #1;
        check("stall", "valid_after_take", {31'b0, valid_out}, 32'd0);
        check("stall", "ready_after_take", {31'b0, ready_out}, 32'd1);
        @(posedge clk_in);
        #1;
        check("stall", "still_idle", {31'b0, ready_out}, 32'd1);

        // Reset pulse while shifting; in-flight operand must vanish.
        valid_in    = 1'b1;
        sum_in      = 25'h0000001;
        exponent_in = 8'h80;
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
        repeat (5) @(posedge clk_in);
        #1;
        check("rst_mid", "busy", {31'b0, ready_out}, 32'd0);
        #2;
        rst_n_in = 1'b0;
        #1;
        check("rst_mid", "ready_now", {31'b0, ready_out}, 32'd1);
        check("rst_mid", "valid_now", {31'b0, valid_out}, 32'd0);
        check("rst_mid", "mant_now", {9'b0, mentissa_out}, 32'd0);
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk_in);
            #1;
            if (valid_out || !ready_out) bad = 1'b1;
        end
        check("rst_mid", "no_stale_result", {31'b0, bad}, 32'd0);
        run_op(vecs[1], "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
